pcss_link_bridge: RTL and testbench

PCSS_LINK_BRIDGE -- requirements
Module: pcss_link_bridge

---
 rtl/pcss_link_bridge.sv | 218 +++++++++++++++++++++
 tb/tb_pcss_link_bridge.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcss_link_bridge.sv
// pcss_link_bridge: bridges a host AXI-stream pair onto NCH parity-protected chip-link channels, plus a timestep generator
// Ports:
//   clk, rst_n                      clock; asynchronous active-low reset
//   s_axis_tdata/tvalid/tdest/tready  host send stream, tdest selects the outgoing channel
//   m_axis_tdata/tvalid/tuser/tready  host receive stream, tuser reports the source channel
//   send_data_out/valid/par          per-channel transmit beats (out); send_data_ready/err (in)
//   recv_data_in/valid/par           per-channel receive beats (in); recv_data_ready/err (out)
//   tik_en, tik_period               timestep enable and period in cycles
//   tik, tik_cnt                     one-cycle timestep pulse and wrapping timestep count
//   send_err_cnt                     saturating count of transmit beats rejected by the link
module pcss_link_bridge #(
   parameter int DATA_WIDTH     = 64,
   parameter int CHIPDATA_WIDTH = 16,
   parameter int NCH            = 4,
   parameter bit PAR_ODD        = 1'b0,
   localparam int CW            = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
   input  logic                          s_axis_tvalid,
   input  logic [CW-1:0]                 s_axis_tdest,
   output logic                          s_axis_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   output logic [CW-1:0]                 m_axis_tuser,
   input  logic                          m_axis_tready,
   output logic [NCH*CHIPDATA_WIDTH-1:0] send_data_out,
   output logic [NCH-1:0]                send_data_valid,
   output logic [NCH-1:0]                send_data_par,
   input  logic [NCH-1:0]                send_data_ready,
   input  logic [NCH-1:0]                send_data_err,
   input  logic [NCH*CHIPDATA_WIDTH-1:0] recv_data_in,
   input  logic [NCH-1:0]                recv_data_valid,
   input  logic [NCH-1:0]                recv_data_par,
   output logic [NCH-1:0]                recv_data_ready,
   output logic [NCH-1:0]                recv_data_err,
   input  logic                          tik_en,
   input  logic [15:0]                   tik_period,
   output logic                          tik,
   output logic [7:0]                    tik_cnt,
   output logic [7:0]                    send_err_cnt
);
   localparam int CD    = CHIPDATA_WIDTH;
   localparam int RATIO = DATA_WIDTH / CHIPDATA_WIDTH;
   localparam int BW    = $clog2(RATIO);
   typedef enum logic {S_IDLE, S_SEND} send_state_t;
   typedef enum logic {R_SCAN, R_COLLECT} recv_state_t;
   send_state_t send_state_q, send_state_d;
   recv_state_t recv_state_q, recv_state_d;
   logic [DATA_WIDTH-1:0] send_word_q, send_word_d, recv_word_q, recv_word_d, m_data_q, m_data_d;
   logic [CW-1:0] send_dest_q, send_dest_d, rr_q, rr_d, recv_ch_q, recv_ch_d, m_user_q, m_user_d;
   logic [BW-1:0] send_beat_q, send_beat_d, recv_beat_q, recv_beat_d;
   logic [7:0] send_err_cnt_q, send_err_cnt_d, tik_cnt_q, tik_cnt_d;
   logic [15:0] tik_ctr_q, tik_ctr_d, tik_last;
   logic m_valid_q, m_valid_d;
   logic [CD-1:0] send_beat, recv_beat;
   logic send_rdy, send_err, recv_vld, recv_par, recv_rdy, recv_take, recv_bad, scan_hit;
   logic [CW-1:0] scan_ch, scan_idx;
   logic [DATA_WIDTH-1:0] recv_shift;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tuser  = m_user_q;
   assign tik_cnt       = tik_cnt_q;
   assign send_err_cnt  = send_err_cnt_q;
   // Transmit: the held word is shifted left per accepted beat, so the top slice is always the current beat
   always_comb begin
      send_state_d    = send_state_q;
      send_word_d     = send_word_q;
      send_dest_d     = send_dest_q;
      send_beat_d     = send_beat_q;
      send_err_cnt_d  = send_err_cnt_q;
      send_beat       = send_word_q[DATA_WIDTH-1 -: CD];
      send_rdy        = 1'b0;
      send_err        = 1'b0;
      send_data_out   = '0;
      send_data_valid = '0;
      send_data_par   = '0;
      s_axis_tready   = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (send_dest_q == CW'(i)) begin
            send_rdy = send_data_ready[i];
            send_err = send_data_err[i];
         end
      end
      if (send_state_q == S_IDLE) begin
         s_axis_tready = rst_n;
         // Words addressed past the last channel are consumed without leaving IDLE
         if (s_axis_tvalid && rst_n && ({1'b0, s_axis_tdest} < (CW+1)'(NCH))) begin
            send_word_d  = s_axis_tdata;
            send_dest_d  = s_axis_tdest;
            send_beat_d  = '0;
            send_state_d = S_SEND;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (send_dest_q == CW'(i)) begin
               send_data_valid[i]        = 1'b1;
               send_data_out[i*CD +: CD] = send_beat;
               send_data_par[i]          = ^send_beat ^ PAR_ODD;
            end
         end
         if (send_rdy && send_err) begin
            send_err_cnt_d = (send_err_cnt_q == 8'hFF) ? send_err_cnt_q : send_err_cnt_q + 8'd1;
         end else if (send_rdy) begin
            send_word_d  = send_word_q << CD;
            send_beat_d  = send_beat_q + BW'(1);
            send_state_d = (send_beat_q == BW'(RATIO-1)) ? S_IDLE : S_SEND;
         end
      end
   end
   // Receive: round-robin channel lock, parity-checked beat collection, single-entry output register
   always_comb begin
      recv_state_d    = recv_state_q;
      recv_word_d     = recv_word_q;
      recv_ch_d       = recv_ch_q;
      recv_beat_d     = recv_beat_q;
      rr_d            = rr_q;
      m_data_d        = m_data_q;
      m_user_d        = m_user_q;
      m_valid_d       = m_valid_q & ~m_axis_tready;
      recv_data_ready = '0;
      recv_data_err   = '0;
      recv_beat       = '0;
      recv_vld        = 1'b0;
      recv_par        = 1'b0;
      scan_hit        = 1'b0;
      scan_ch         = rr_q;
      scan_idx        = rr_q;
      for (int i = 0; i < NCH; i++) begin
         if (recv_ch_q == CW'(i)) begin
            recv_beat = recv_data_in[i*CD +: CD];
            recv_vld  = recv_data_valid[i];
            recv_par  = recv_data_par[i];
         end
      end
      // Walk offsets from the top down so the smallest offset from rr is the one left standing
      for (int k = NCH-1; k >= 0; k--) begin
         scan_idx = CW'((int'(rr_q) + k) % NCH);
         if (recv_data_valid[scan_idx]) begin
            scan_hit = 1'b1;
            scan_ch  = scan_idx;
         end
      end
      // The last beat waits until the output register can take the finished word
      recv_rdy   = ~((recv_beat_q == BW'(RATIO-1)) & m_valid_q & ~m_axis_tready);
      recv_take  = (recv_state_q == R_COLLECT) & recv_vld & recv_rdy;
      recv_bad   = (^recv_beat ^ PAR_ODD) != recv_par;
      recv_shift = (recv_word_q << CD) | DATA_WIDTH'(recv_beat);
      if (recv_state_q == R_SCAN) begin
         if (scan_hit) begin
            recv_ch_d    = scan_ch;
            rr_d         = (scan_ch == CW'(NCH-1)) ? '0 : scan_ch + CW'(1);
            recv_beat_d  = '0;
            recv_state_d = R_COLLECT;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (recv_ch_q == CW'(i)) begin
               recv_data_ready[i] = recv_rdy;
               recv_data_err[i]   = recv_take & recv_bad;
            end
         end
         if (recv_take && !recv_bad) begin
            recv_word_d = recv_shift;
            recv_beat_d = recv_beat_q + BW'(1);
            if (recv_beat_q == BW'(RATIO-1)) begin
               m_data_d     = recv_shift;
               m_user_d     = recv_ch_q;
               m_valid_d    = 1'b1;
               recv_state_d = R_SCAN;
            end
         end
      end
   end
   // Timestep: a count beyond a freshly lowered period wraps at once without a pulse
   always_comb begin
      tik_last  = tik_period - 16'd1;
      tik       = rst_n & tik_en & (tik_period != 16'd0) & (tik_ctr_q == tik_last);
      tik_ctr_d = (tik_en && tik_period != 16'd0 && tik_ctr_q < tik_last) ? tik_ctr_q + 16'd1 : 16'd0;
      tik_cnt_d = tik ? tik_cnt_q + 8'd1 : tik_cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         send_state_q   <= S_IDLE;
         send_word_q    <= '0;
         send_dest_q    <= '0;
         send_beat_q    <= '0;
         send_err_cnt_q <= '0;
         recv_state_q   <= R_SCAN;
         recv_word_q    <= '0;
         recv_ch_q      <= '0;
         recv_beat_q    <= '0;
         rr_q           <= '0;
         m_data_q       <= '0;
         m_user_q       <= '0;
         m_valid_q      <= 1'b0;
         tik_ctr_q      <= '0;
         tik_cnt_q      <= '0;
      end else begin
         send_state_q   <= send_state_d;
         send_word_q    <= send_word_d;
         send_dest_q    <= send_dest_d;
         send_beat_q    <= send_beat_d;
         send_err_cnt_q <= send_err_cnt_d;
         recv_state_q   <= recv_state_d;
         recv_word_q    <= recv_word_d;
         recv_ch_q      <= recv_ch_d;
         recv_beat_q    <= recv_beat_d;
         rr_q           <= rr_d;
         m_data_q       <= m_data_d;
         m_user_q       <= m_user_d;
         m_valid_q      <= m_valid_d;
         tik_ctr_q      <= tik_ctr_d;
         tik_cnt_q      <= tik_cnt_d;
      end
   end
endmodule

// File: tb/tb_pcss_link_bridge.sv
// tb_pcss_link_bridge: directed and randomized checks of pcss_link_bridge against a queue-based link model
module tb_pcss_link_bridge;
   logic clk = 1'b0;
   logic rst_n;
   logic [63:0] s_axis_tdata, m_axis_tdata, send_data_out, recv_data_in;
   logic s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready, tik_en, tik;
   logic [1:0] s_axis_tdest, m_axis_tuser;
   logic [3:0] send_data_valid, send_data_par, send_data_ready, send_data_err;
   logic [3:0] recv_data_valid, recv_data_par, recv_data_ready, recv_data_err;
   logic [15:0] tik_period;
   logic [7:0] tik_cnt, send_err_cnt;
   int checks = 0, errors = 0, err_m = 0, rr_m = 0, last_cyc = 0;
   logic [63:0] rw [4];
   int rbad [4];
   bit rmask [4];

   pcss_link_bridge #(.DATA_WIDTH(64), .CHIPDATA_WIDTH(16), .NCH(4), .PAR_ODD(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tdest(s_axis_tdest), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
      .send_data_out(send_data_out), .send_data_valid(send_data_valid), .send_data_par(send_data_par),
      .send_data_ready(send_data_ready), .send_data_err(send_data_err),
      .recv_data_in(recv_data_in), .recv_data_valid(recv_data_valid), .recv_data_par(recv_data_par),
      .recv_data_ready(recv_data_ready), .recv_data_err(recv_data_err),
      .tik_en(tik_en), .tik_period(tik_period), .tik(tik), .tik_cnt(tik_cnt), .send_err_cnt(send_err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic par(input logic [15:0] b);
      return ^b;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // err mode: -1 none, -2 random, -3 held for the first 260 link cycles, >=0 only on that link cycle
   task automatic send_word(input logic [63:0] w, input logic [1:0] d, input int mode, input bit rnd);
      logic [15:0] q[$];
      logic [3:0] oh, pv;
      int cyc;
      bit r, e;
      cyc = 0;
      oh = 4'b0001 << d;
      for (int k = 0; k < 4; k++) q.push_back(w[63-16*k -: 16]);
      @(negedge clk);
      s_axis_tdata = w;
      s_axis_tdest = d;
      s_axis_tvalid = 1'b1;
      #1 chk("s_ready_idle", s_axis_tready, 1);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tdata = '0;
      while (q.size() > 0 && cyc < 400) begin
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         e = (mode == -2) ? ($urandom_range(0, 3) == 0) : (mode == -3) ? (cyc < 260) : (cyc == mode);
         send_data_ready = r ? oh : ~oh;
         send_data_err = e ? oh : ~oh;
         pv = {3'b000, par(q[0])} << d;
         #1;
         chk("s_valid", send_data_valid, oh);
         chk("s_beat", send_data_out[16*d +: 16], q[0]);
         chk("s_par", send_data_par, pv);
         chk("s_ready_busy", s_axis_tready, 0);
         @(posedge clk);
         if (r && e) err_m = (err_m < 255) ? err_m + 1 : 255;
         else if (r) void'(q.pop_front());
         cyc++;
         @(negedge clk);
      end
      send_data_ready = '0;
      send_data_err = '0;
      last_cyc = cyc;
      chk("s_done", q.size(), 0);
      #1;
      chk("s_ready_back", s_axis_tready, 1);
      chk("s_valid_off", send_data_valid, 0);
      chk("s_err_cnt", send_err_cnt, err_m);
   endtask

   // Presents rw[c] on every channel with rmask[c]; a bad-parity copy precedes beat rbad[c]
   task automatic recv_run(input int stall, input bit rnd);
      logic [15:0] bt [4][5];
      bit bb [4][5];
      int pos [4], len [4];
      bit hs [4];
      logic [63:0] ew [4];
      int eu [4];
      int ne, hi, cyc, n, c;
      logic [3:0] eerr;
      ne = 0; hi = 0; cyc = 0;
      for (int ch = 0; ch < 4; ch++) begin
         n = 0;
         for (int k = 0; k < 4; k++) begin
            if (rbad[ch] == k) begin
               bt[ch][n] = rw[ch][63-16*k -: 16];
               bb[ch][n] = 1'b1;
               n++;
            end
            bt[ch][n] = rw[ch][63-16*k -: 16];
            bb[ch][n] = 1'b0;
            n++;
         end
         len[ch] = rmask[ch] ? n : 0;
         pos[ch] = 0;
      end
      for (int k = 0; k < 4; k++) begin
         c = (rr_m + k) % 4;
         if (rmask[c]) begin
            ew[ne] = rw[c];
            eu[ne] = c;
            ne++;
         end
      end
      if (ne > 0) rr_m = (eu[ne-1] + 1) % 4;
      @(negedge clk);
      while (hi < ne && cyc < 600) begin
         for (int ch = 0; ch < 4; ch++) begin
            if (pos[ch] < len[ch]) begin
               recv_data_valid[ch] = 1'b1;
               recv_data_in[16*ch +: 16] = bt[ch][pos[ch]];
               recv_data_par[ch] = par(bt[ch][pos[ch]]) ^ bb[ch][pos[ch]];
            end else begin
               recv_data_valid[ch] = 1'b0;
               recv_data_in[16*ch +: 16] = '0;
               recv_data_par[ch] = 1'b0;
            end
         end
         m_axis_tready = (cyc < stall) ? 1'b0 : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         eerr = '0;
         for (int ch = 0; ch < 4; ch++) begin
            hs[ch] = recv_data_valid[ch] & recv_data_ready[ch];
            eerr[ch] = hs[ch] && bb[ch][pos[ch]];
         end
         chk("r_err", recv_data_err, eerr);
         chk("r_one_ready", $countones(recv_data_ready) <= 1, 1);
         if (stall > 0 && cyc == stall - 1) begin
            chk("r_stall_ready", recv_data_ready, 0);
            chk("r_stall_valid", m_axis_tvalid, 1);
         end
         if (m_axis_tvalid) begin
            chk("r_data", m_axis_tdata, ew[hi]);
            chk("r_user", m_axis_tuser, eu[hi]);
            if (m_axis_tready) hi++;
         end
         @(posedge clk);
         for (int ch = 0; ch < 4; ch++) if (hs[ch]) pos[ch]++;
         cyc++;
         @(negedge clk);
      end
      recv_data_valid = '0;
      m_axis_tready = 1'b0;
      chk("r_done", hi, ne);
      chk("r_consumed", pos[0] + pos[1] + pos[2] + pos[3], len[0] + len[1] + len[2] + len[3]);
   endtask

   initial begin
      rst_n = 1'b0;
      s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tdest = '0;
      m_axis_tready = 1'b0;
      send_data_ready = '0; send_data_err = '0;
      recv_data_in = '0; recv_data_valid = '0; recv_data_par = '0;
      tik_en = 1'b1; tik_period = 16'd1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_s_ready", s_axis_tready, 0);
      chk("rst_m_valid", m_axis_tvalid, 0);
      chk("rst_m_data", m_axis_tdata, 0);
      chk("rst_m_user", m_axis_tuser, 0);
      chk("rst_send_valid", send_data_valid, 0);
      chk("rst_send_data", send_data_out, 0);
      chk("rst_recv_ready", recv_data_ready, 0);
      chk("rst_recv_err", recv_data_err, 0);
      chk("rst_tik", tik, 0);
      chk("rst_tik_cnt", tik_cnt, 0);
      chk("rst_err_cnt", send_err_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tik_en = 1'b0;
      #1 chk("rel_s_ready", s_axis_tready, 1);

      send_word(64'h0123_4567_89AB_CDEF, 2'd2, -1, 1'b0);
      chk("plain_cycles", last_cyc, 4);
      send_word(64'h0123_4567_89AB_CDEF, 2'd2, 1, 1'b0);
      chk("err_cycles", last_cyc, 5);
      chk("err_cnt_one", send_err_cnt, 1);
      for (int t = 0; t < 6; t++) send_word({$urandom, $urandom}, 2'($urandom_range(0, 3)), -2, 1'b1);
      send_word({$urandom, $urandom}, 2'd3, -3, 1'b0);
      chk("err_cnt_sat", send_err_cnt, 255);

      rw[0] = 64'h1111_2222_3333_4444; rw[3] = 64'hAAAA_BBBB_CCCC_DDDD;
      rmask = '{1'b1, 1'b0, 1'b0, 1'b1};
      rbad = '{-1, -1, -1, -1};
      recv_run(0, 1'b0);
      rw[1] = 64'hFEDC_BA98_7654_3210; rw[2] = 64'h0F0F_F0F0_5A5A_A5A5;
      rmask = '{1'b0, 1'b1, 1'b1, 1'b0};
      rbad = '{-1, 2, 3, -1};
      recv_run(40, 1'b0);
      for (int t = 0; t < 6; t++) begin
         for (int ch = 0; ch < 4; ch++) begin
            rw[ch] = {$urandom, $urandom};
            rmask[ch] = 1'($urandom_range(0, 1));
            rbad[ch] = int'($urandom_range(0, 4)) - 1;
         end
         rmask[t % 4] = 1'b1;
         recv_run(0, 1'b1);
      end
      for (int ch = 0; ch < 4; ch++) begin
         rw[ch] = {$urandom, $urandom};
         rmask[ch] = 1'b1;
         rbad[ch] = int'($urandom_range(0, 4)) - 1;
      end
      fork
         send_word({$urandom, $urandom}, 2'd1, -2, 1'b1);
         recv_run(0, 1'b1);
      join

      @(negedge clk);
      tik_period = 16'd5;
      tik_en = 1'b1;
      for (int i = 0; i < 1280; i++) begin
         #1;
         chk("tik_p5", tik, (i % 5) == 4);
         chk("tik_cnt_p5", tik_cnt, (i / 5) % 256);
         @(negedge clk);
      end
      #1 chk("tik_cnt_wrap", tik_cnt, 0);
      tik_period = 16'd8;
      for (int i = 0; i <= 10; i++) begin
         if (i == 6) tik_period = 16'd4;
         #1 chk("tik_shrink", tik, i == 10);
         @(negedge clk);
      end
      #1 chk("tik_cnt_shrink", tik_cnt, 1);
      tik_period = 16'd0;
      for (int i = 0; i < 5; i++) begin
         #1 chk("tik_p0", tik, 0);
         @(negedge clk);
      end
      tik_period = 16'd1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("tik_p1", tik, 1);
         @(negedge clk);
      end
      #1 chk("tik_cnt_p1", tik_cnt, 4);
      tik_en = 1'b0;
      #1 chk("tik_off", tik, 0);

      @(negedge clk);
      s_axis_tdata = 64'hDEAD_BEEF_CAFE_F00D;
      s_axis_tdest = 2'd1;
      s_axis_tvalid = 1'b1;
      recv_data_valid = 4'b0001;
      recv_data_in = 64'h0000_0000_0000_1234;
      recv_data_par = {3'b000, par(16'h1234)};
      m_axis_tready = 1'b1;
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      send_data_ready = 4'b0010;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", send_data_valid, 0);
      chk("mid_rst_data", send_data_out, 0);
      chk("mid_rst_s_ready", s_axis_tready, 0);
      chk("mid_rst_r_ready", recv_data_ready, 0);
      chk("mid_rst_err_cnt", send_err_cnt, 0);
      chk("mid_rst_tik_cnt", tik_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      recv_data_valid = '0;
      send_data_ready = '0;
      m_axis_tready = 1'b0;
      err_m = 0;
      rr_m = 0;
      #1 chk("mid_rel_s_ready", s_axis_tready, 1);
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("no_replay_send", send_data_valid, 0);
         chk("no_replay_recv", m_axis_tvalid, 0);
      end
      send_word(64'h0123_4567_89AB_CDEF, 2'd0, -1, 1'b0);
      rw[0] = 64'h0BAD_F00D_1234_5678;
      rmask = '{1'b1, 1'b0, 1'b0, 1'b0};
      rbad = '{-1, -1, -1, -1};
      recv_run(0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
